// File: rtl/nbody_step_sequencer_if.sv
// Control/status bundle between the bus register file and the n-body step sequencer.
// The master drives the command side; the sequencer (slave) drives every strobe and address.
interface nbody_step_sequencer_if #(
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int STEP_WIDTH      = 16
);
    logic                       start;
    logic                       abort;
    logic                       done_ack;
    logic [BODY_ADDR_WIDTH:0]   num_bodies;
    logic [STEP_WIDTH-1:0]      num_steps;
    logic                       skip_self;

    logic                       pair_valid;
    logic [BODY_ADDR_WIDTH-1:0] pair_i;
    logic [BODY_ADDR_WIDTH-1:0] pair_j;
    logic                       acc_valid;
    logic [BODY_ADDR_WIDTH-1:0] acc_i;
    logic                       acc_row_last;
    logic                       vel_wr_en;
    logic [BODY_ADDR_WIDTH-1:0] vel_wr_addr;
    logic                       pos_rd_valid;
    logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr;
    logic                       pos_wr_en;
    logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr;
    logic                       first_step;
    logic                       busy;
    logic                       done;
    logic [STEP_WIDTH-1:0]      step_count;

    modport master (
        output start, abort, done_ack, num_bodies, num_steps, skip_self,
        input  pair_valid, pair_i, pair_j, acc_valid, acc_i, acc_row_last,
               vel_wr_en, vel_wr_addr, pos_rd_valid, pos_rd_addr, pos_wr_en,
               pos_wr_addr, first_step, busy, done, step_count
    );

    modport slave (
        input  start, abort, done_ack, num_bodies, num_steps, skip_self,
        output pair_valid, pair_i, pair_j, acc_valid, acc_i, acc_row_last,
               vel_wr_en, vel_wr_addr, pos_rd_valid, pos_rd_addr, pos_wr_en,
               pos_wr_addr, first_step, busy, done, step_count
    );
endinterface

// File: rtl/nbody_step_sequencer.sv
// Leapfrog step sequencer: issues all-pairs acceleration reads, then per-body position
// updates, for S steps; downstream strobes come from fixed-latency shift registers.
module nbody_step_sequencer #(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int STEP_WIDTH      = 16,
    parameter int ACCL_LATENCY    = 137,
    parameter int ADD_LATENCY     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    nbody_step_sequencer_if.slave ctl
);
    localparam int AW    = BODY_ADDR_WIDTH;
    localparam int NW    = AW + 1;
    localparam int DRAIN = ACCL_LATENCY + ADD_LATENCY;
    localparam int CW    = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {IDLE, ACCEL_ISSUE, ACCEL_DRAIN, POS_ISSUE, POS_DRAIN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [NW-1:0]         n_reg, n_next;
    logic [STEP_WIDTH-1:0] s_reg, s_next;
    logic                  skip_reg, skip_next;
    logic                  pair_valid_reg, pair_valid_next;
    logic [AW-1:0]         pair_i_reg, pair_i_next;
    logic [AW-1:0]         pair_j_reg, pair_j_next;
    logic                  pos_rd_valid_reg, pos_rd_valid_next;
    logic [AW-1:0]         pos_rd_addr_reg, pos_rd_addr_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [STEP_WIDTH-1:0] step_count_reg, step_count_next;
    logic                  first_step_reg, first_step_next;

    logic [NW-1:0] i_ext, j_ext, j_inc;
    logic          row_last, last_pair, line_clear;

    assign i_ext = {1'b0, pair_i_reg};
    assign j_ext = {1'b0, pair_j_reg};
    // With self-pair skipping the final row stops at N-2 because its own slot is N-1.
    assign row_last  = (j_ext + NW'(1) == n_reg) ||
                       (skip_reg && (i_ext + NW'(1) == n_reg) && (j_ext + NW'(2) == n_reg));
    assign last_pair = row_last && (i_ext + NW'(1) == n_reg);
    assign j_inc     = (skip_reg && (j_ext + NW'(1) == i_ext)) ? j_ext + NW'(2) : j_ext + NW'(1);
    assign line_clear = rst | ctl.abort;

    always_comb begin
        state_next        = state_reg;
        n_next            = n_reg;
        s_next            = s_reg;
        skip_next         = skip_reg;
        pair_valid_next   = 1'b0;
        pair_i_next       = pair_i_reg;
        pair_j_next       = pair_j_reg;
        pos_rd_valid_next = 1'b0;
        pos_rd_addr_next  = pos_rd_addr_reg;
        cnt_next          = cnt_reg;
        step_count_next   = step_count_reg;
        first_step_next   = first_step_reg;
        if (ctl.abort) begin
            state_next       = IDLE;
            pair_i_next      = '0;
            pair_j_next      = '0;
            pos_rd_addr_next = '0;
            cnt_next         = '0;
            first_step_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ctl.start) begin
                        step_count_next = '0;
                        if (ctl.num_bodies >= NW'(2) && ctl.num_steps != '0) begin
                            n_next          = ctl.num_bodies;
                            s_next          = ctl.num_steps;
                            skip_next       = ctl.skip_self;
                            first_step_next = 1'b1;
                            state_next      = ACCEL_ISSUE;
                            pair_valid_next = 1'b1;
                            pair_i_next     = '0;
                            pair_j_next     = AW'(ctl.skip_self);
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                ACCEL_ISSUE: begin
                    if (last_pair) begin
                        state_next = ACCEL_DRAIN;
                        cnt_next   = '0;
                    end else begin
                        pair_valid_next = 1'b1;
                        if (row_last) begin
                            pair_i_next = pair_i_reg + AW'(1);
                            pair_j_next = '0;
                        end else begin
                            pair_j_next = j_inc[AW-1:0];
                        end
                    end
                end
                ACCEL_DRAIN: begin
                    if (cnt_reg == CW'(DRAIN - 1)) begin
                        state_next        = POS_ISSUE;
                        pos_rd_valid_next = 1'b1;
                        pos_rd_addr_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                POS_ISSUE: begin
                    if ({1'b0, pos_rd_addr_reg} + NW'(1) == n_reg) begin
                        state_next = POS_DRAIN;
                        cnt_next   = '0;
                    end else begin
                        pos_rd_valid_next = 1'b1;
                        pos_rd_addr_next  = pos_rd_addr_reg + AW'(1);
                    end
                end
                POS_DRAIN: begin
                    if (cnt_reg == CW'(ADD_LATENCY)) begin
                        step_count_next = step_count_reg + STEP_WIDTH'(1);
                        first_step_next = 1'b0;
                        if (step_count_reg + STEP_WIDTH'(1) == s_reg) begin
                            state_next = DONE;
                        end else begin
                            state_next      = ACCEL_ISSUE;
                            pair_valid_next = 1'b1;
                            pair_i_next     = '0;
                            pair_j_next     = AW'(skip_reg);
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (ctl.done_ack) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            n_reg            <= '0;
            s_reg            <= '0;
            skip_reg         <= 1'b0;
            pair_valid_reg   <= 1'b0;
            pair_i_reg       <= '0;
            pair_j_reg       <= '0;
            pos_rd_valid_reg <= 1'b0;
            pos_rd_addr_reg  <= '0;
            cnt_reg          <= '0;
            step_count_reg   <= '0;
            first_step_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            n_reg            <= n_next;
            s_reg            <= s_next;
            skip_reg         <= skip_next;
            pair_valid_reg   <= pair_valid_next;
            pair_i_reg       <= pair_i_next;
            pair_j_reg       <= pair_j_next;
            pos_rd_valid_reg <= pos_rd_valid_next;
            pos_rd_addr_reg  <= pos_rd_addr_next;
            cnt_reg          <= cnt_next;
            step_count_reg   <= step_count_next;
            first_step_reg   <= first_step_next;
        end
    end

    // Delay lines free-run through every state; only rst/abort flush them.
    genvar gi;
    generate
        for (gi = 0; gi < ACCL_LATENCY; gi++) begin : g_acc
            logic [AW+1:0] stage;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (line_clear) stage <= '0;
                    else stage <= {pair_valid_reg, pair_valid_reg & row_last, pair_i_reg};
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (line_clear) stage <= '0;
                    else stage <= g_acc[gi-1].stage;
                end
            end
        end

        for (gi = 0; gi < ADD_LATENCY; gi++) begin : g_vel
            logic [AW:0] stage;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (line_clear) stage <= '0;
                    else stage <= {ctl.acc_valid & ctl.acc_row_last, ctl.acc_i};
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (line_clear) stage <= '0;
                    else stage <= g_vel[gi-1].stage;
                end
            end
        end

        for (gi = 0; gi < ADD_LATENCY + 1; gi++) begin : g_pos
            logic [AW:0] stage;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (line_clear) stage <= '0;
                    else stage <= {pos_rd_valid_reg, pos_rd_addr_reg};
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (line_clear) stage <= '0;
                    else stage <= g_pos[gi-1].stage;
                end
            end
        end
    endgenerate

    assign ctl.pair_valid   = pair_valid_reg;
    assign ctl.pair_i       = pair_i_reg;
    assign ctl.pair_j       = pair_j_reg;
    assign ctl.acc_valid    = g_acc[ACCL_LATENCY-1].stage[AW+1];
    assign ctl.acc_row_last = g_acc[ACCL_LATENCY-1].stage[AW];
    assign ctl.acc_i        = g_acc[ACCL_LATENCY-1].stage[AW-1:0];
    assign ctl.vel_wr_en    = g_vel[ADD_LATENCY-1].stage[AW];
    assign ctl.vel_wr_addr  = g_vel[ADD_LATENCY-1].stage[AW-1:0];
    assign ctl.pos_rd_valid = pos_rd_valid_reg;
    assign ctl.pos_rd_addr  = pos_rd_addr_reg;
    assign ctl.pos_wr_en    = g_pos[ADD_LATENCY].stage[AW];
    assign ctl.pos_wr_addr  = g_pos[ADD_LATENCY].stage[AW-1:0];
    assign ctl.first_step   = first_step_reg;
    assign ctl.busy         = (state_reg != IDLE) && (state_reg != DONE);
    assign ctl.done         = (state_reg == DONE);
    assign ctl.step_count   = step_count_reg;
endmodule

// File: doc/nbody_step_sequencer.md
Name: nbody_step_sequencer

Overview:
Parametrised control core for the next-generation n-body accelerator. It sequences any number of leapfrog steps per start command, producing all memory addresses and valid strobes for the acceleration/velocity phase and the position phase; it contains no datapath. The latencies of the acceleration pipeline and of the adder are parameters, and the block adds self-pair skipping, a first-step flag, abort, and a done/ack handshake. It sits between the bus register file and the getAccl/AddSub/RAM datapath.

Parameters:
BODIES, 512, maximum body count.
BODY_ADDR_WIDTH, $clog2(BODIES), width of body indices.
STEP_WIDTH, 16, width of the step counters.
ACCL_LATENCY, 137, cycles from a pair issue to its acceleration result (>=1).
ADD_LATENCY, 20, AddSub latency in cycles (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle start pulse; ignored unless in IDLE
abort  in  1  return to IDLE
done_ack  in  1  software acknowledge of done
num_bodies  in  BODY_ADDR_WIDTH+1  body count N, latched on start
num_steps  in  STEP_WIDTH  step count S, latched on start
skip_self  in  1  omit pairs with i==j, latched on start
pair_valid  out  1  pair_i/pair_j valid this cycle
pair_i, pair_j  out  BODY_ADDR_WIDTH  position/mass read addresses
acc_valid  out  1  pair_valid delayed ACCL_LATENCY
acc_i  out  BODY_ADDR_WIDTH  pair_i delayed ACCL_LATENCY
acc_row_last  out  1  qualifies acc_valid: last j of row acc_i
vel_wr_en  out  1  (acc_valid & acc_row_last) delayed ADD_LATENCY
vel_wr_addr  out  BODY_ADDR_WIDTH  acc_i delayed ADD_LATENCY
pos_rd_valid  out  1  position-phase read strobe
pos_rd_addr  out  BODY_ADDR_WIDTH  position/velocity read address
pos_wr_en  out  1  pos_rd_valid delayed 1+ADD_LATENCY
pos_wr_addr  out  BODY_ADDR_WIDTH  pos_rd_addr delayed 1+ADD_LATENCY
first_step  out  1  high during step 0 (half-kick)
busy  out  1  state != IDLE and state != DONE
done  out  1  high in DONE
step_count  out  STEP_WIDTH  number of completed steps

Behaviour:
- Reset: state IDLE; all outputs 0; all delay lines cleared.
- States: IDLE, ACCEL_ISSUE, ACCEL_DRAIN, POS_ISSUE, POS_DRAIN, DONE. Outputs are registered.
- IDLE: start with N>=2 and S>=1 latches N, S and skip_self, clears step_count, sets first_step=1, and enters ACCEL_ISSUE; the first pair appears the next cycle. Start with N<2 or S==0 goes straight to DONE with step_count=0.
- ACCEL_ISSUE: one pair per cycle, no bubbles. i is the outer loop (0..N-1) and j the inner loop (0..N-1). With skip_self, the j==i slot is skipped without spending a cycle (i=0 starts at j=1; a row whose last j equals i ends at j=N-2). The row-last flag travels with each pair. Pairs per step: N*N, or N*(N-1) with skip_self. After the last pair, go to ACCEL_DRAIN.
- ACCEL_DRAIN: exactly ACCL_LATENCY+ADD_LATENCY cycles (counter), then POS_ISSUE.
- POS_ISSUE: pos_rd_addr runs 0..N-1 over N consecutive cycles with pos_rd_valid=1, then POS_DRAIN.
- POS_DRAIN: exactly 1+ADD_LATENCY cycles. On its last cycle: step_count+1, first_step=0. If step_count+1==S go to DONE, else go to ACCEL_ISSUE.
- Cycle count per step: P + ACCL_LATENCY + 2*ADD_LATENCY + N + 1, where P is the pairs per step.
- DONE: done=1 is held until done_ack, then IDLE next cycle. start in DONE is ignored. done_ack outside DONE is ignored.
- Delay lines: shift registers, independent of state. They run through the drain states.
- abort, any state: IDLE next cycle; every valid, write enable and delay-line stage cleared; step_count holds its value. abort has priority over start and done_ack.
- rst mid-operation: same clearing as abort, plus step_count=0.
- Counters never wrap past N-1; latched inputs are unaffected by port changes while busy.

Test Plan:
- N=3, S=1, skip_self=1, ACCL_LATENCY=4, ADD_LATENCY=2, start at cycle 0 -> pairs (0,1)(0,2)(1,0)(1,2)(2,0)(2,1) on cycles 1-6; acc_valid on cycles 5-10; vel_wr_en at cycles 8/10/12 with addr 0/1/2; pos_rd 0,1,2 on cycles 13-15; pos_wr on cycles 16-18; done rises at cycle 19.
- Same configuration, S=3 -> done at cycle 55; first_step high only during cycles 1-18; step_count reads 3.
- N=2, skip_self=0 -> pairs (0,0)(0,1)(1,0)(1,1); acc_row_last set on j=1 only.
- start with N=1 -> done the next cycle, with no pair_valid or pos_rd_valid ever asserted; done_ack -> IDLE.
- abort during ACCEL_DRAIN -> next cycle all strobes are 0 and stay 0, including pending vel_wr_en; busy=0; a new start then runs normally.
- start asserted while busy and done_ack outside DONE -> no effect; the sequence timing is identical to the first scenario.
